// File: rtl/prescaler_pkg.sv
// prescaler_pkg
// Shared constants for the programmable prescaler: run-mode encodings,
// FSM state encoding and a helper that tells counted modes from free-run.
package prescaler_pkg;

    localparam logic [1:0] MODE_CONT    = 2'b00;
    localparam logic [1:0] MODE_ONESHOT = 2'b01;
    localparam logic [1:0] MODE_BURST   = 2'b10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // One-shot and burst terminate after a pulse count; 00 and 11 free-run.
    function automatic logic is_counted_mode(input logic [1:0] m);
        return (m == MODE_ONESHOT) || (m == MODE_BURST);
    endfunction

endpackage

// File: rtl/prescaler_phase.sv
// prescaler_phase
// Period register, phase counter and registered p_e generation.
// Ports:
//   clk, rst       - clock, synchronous active-low reset
//   run            - FSM is in RUN; counting only happens while high
//   en             - count enable (0 holds the phase)
//   load           - capture period_in and restart the phase at 0
//   clear          - restart the phase at 0 (stop in RUN, or run start)
//   period_in      - new period value
//   p_e            - registered one-cycle enable pulse
//   tick           - combinational: a pulse is being issued on this edge
module prescaler_phase #(
    parameter int WIDTH          = 8,
    parameter int DEFAULT_PERIOD = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             en,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] period_in,
    output logic             p_e,
    output logic             tick
);

    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] phase_q, phase_d;
    logic             p_e_q, p_e_d;
    logic [WIDTH-1:0] last_phase;
    logic             count_en;

    // A period of 0 behaves as 1, so the last phase is 0 in both cases.
    assign last_phase = (period_q == '0) ? '0 : period_q - WIDTH'(1);

    // clear and load both win over counting on the same edge.
    assign count_en = run && en && !clear && !load;
    assign tick     = count_en && (phase_q == last_phase);

    always_comb begin
        period_d = period_q;
        phase_d  = phase_q;
        p_e_d    = tick;
        if (load) begin
            period_d = period_in;
        end
        if (clear || load) begin
            phase_d = '0;
        end else if (count_en) begin
            phase_d = tick ? '0 : phase_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            period_q <= WIDTH'(DEFAULT_PERIOD);
            phase_q  <= '0;
            p_e_q    <= 1'b0;
        end else begin
            period_q <= period_d;
            phase_q  <= phase_d;
            p_e_q    <= p_e_d;
        end
    end

    assign p_e = p_e_q;

endmodule

// File: rtl/prescaler_prog.sv
// prescaler_prog
// Runtime-programmable enable-pulse prescaler with continuous, one-shot
// and burst modes. Holds the IDLE/RUN FSM, the burst target and the pulse
// counter; the period/phase datapath lives in prescaler_phase.
// Ports:
//   clk, rst   - clock, synchronous active-low reset
//   en         - count enable
//   load       - strobe: capture period_in
//   period_in  - new period
//   mode       - 00 continuous, 01 one-shot, 10 burst, 11 continuous
//   burst_len  - pulses per burst, sampled on start (0 acts as 1)
//   start      - strobe: begin a one-shot/burst run
//   stop       - strobe: abort the current run
//   p_e        - registered one-cycle enable pulse
//   busy       - FSM is in RUN
//   done       - one-cycle pulse when a one-shot/burst run completes
//   cnt_out    - pulses emitted in the current run
// Control strobes are plain level-sampled pulses: each acts on the edge it
// is high at; there is no valid/ready handshake on this block.
module prescaler_prog
    import prescaler_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int DEFAULT_PERIOD = 5,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             start,
    input  logic             stop,
    output logic             p_e,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt_out
);

    state_e           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic             done_q, done_d;

    logic             in_run;
    logic             stop_run;
    logic             start_go;
    logic             tick;
    logic             finish;
    logic [CNT_W-1:0] cnt_inc;

    assign in_run   = (state_q == ST_RUN);
    assign stop_run = stop && in_run;
    // Explicit start is only needed (and only honoured) in counted modes.
    assign start_go = !in_run && start && is_counted_mode(mode);
    assign cnt_inc  = cnt_q + CNT_W'(1);
    // The pulse issued on this edge is the one that reaches the target.
    assign finish   = in_run && tick && is_counted_mode(mode_q) && (cnt_inc == target_q);

    prescaler_phase #(
        .WIDTH          (WIDTH),
        .DEFAULT_PERIOD (DEFAULT_PERIOD)
    ) u_phase (
        .clk       (clk),
        .rst       (rst),
        .run       (in_run),
        .en        (en),
        .load      (load && !stop_run),
        .clear     (stop_run || start_go),
        .period_in (period_in),
        .p_e       (p_e),
        .tick      (tick)
    );

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (!is_counted_mode(mode) || start_go) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop_run || finish) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy = (state_q == ST_RUN);
    end

    // Run bookkeeping: sampled mode, target and pulse counter.
    always_comb begin
        mode_d   = mode_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        done_d   = finish;
        if (!in_run) begin
            mode_d = mode;
            if (!is_counted_mode(mode) || start_go) begin
                cnt_d = '0;
            end
            if (start_go) begin
                if (mode == MODE_ONESHOT || burst_len == '0) begin
                    target_d = CNT_W'(1);
                end else begin
                    target_d = burst_len;
                end
            end
        end else if (tick) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mode_q   <= MODE_CONT;
            target_q <= CNT_W'(1);
            cnt_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
        end
    end

    assign done    = done_q;
    assign cnt_out = cnt_q;

endmodule

// File: tb/tb_prescaler_prog.sv
module tb_prescaler_prog;

    logic       clk;
    logic       rst;
    logic       en;
    logic       load;
    logic [7:0] period_in;
    logic [1:0] mode;
    logic [7:0] burst_len;
    logic       start;
    logic       stop;
    logic       p_e;
    logic       busy;
    logic       done;
    logic [7:0] cnt_out;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [7:0] period_in;
        logic [1:0] mode;
        logic [7:0] burst_len;
        logic       start;
        logic       stop;
        logic       exp_p_e;
        logic       exp_busy;
        logic       exp_done;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t        vecs[$];
    logic [10:0] exp_q[$];

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    prescaler_prog #(
        .WIDTH          (8),
        .DEFAULT_PERIOD (5),
        .CNT_W          (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .load      (load),
        .period_in (period_in),
        .mode      (mode),
        .burst_len (burst_len),
        .start     (start),
        .stop      (stop),
        .p_e       (p_e),
        .busy      (busy),
        .done      (done),
        .cnt_out   (cnt_out)
    );

    task automatic add(input logic r, input logic e, input logic ld, input logic [7:0] pin,
                       input logic [1:0] m, input logic [7:0] bl, input logic st, input logic sp,
                       input logic xpe, input logic xbusy, input logic xdone, input logic [7:0] xcnt);
        vec_t v;
        v.rst = r; v.en = e; v.load = ld; v.period_in = pin; v.mode = m; v.burst_len = bl;
        v.start = st; v.stop = sp; v.exp_p_e = xpe; v.exp_busy = xbusy; v.exp_done = xdone;
        v.exp_cnt = xcnt;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // driver: apply inputs, take one edge, sample 1 ns later
    task automatic drive(input logic r, input logic e, input logic ld, input logic [7:0] pin,
                         input logic [1:0] m, input logic [7:0] bl, input logic st, input logic sp);
        rst = r; en = e; load = ld; period_in = pin; mode = m; burst_len = bl;
        start = st; stop = sp;
        @(posedge clk);
        #1;
    endtask

    // scoreboard: pop the expected record and compare all outputs
    task automatic score(input string tag);
        logic [10:0] x;
        x = exp_q.pop_front();
        check({tag, " p_e"},  {31'd0, p_e},  {31'd0, x[10]});
        check({tag, " busy"}, {31'd0, busy}, {31'd0, x[9]});
        check({tag, " done"}, {31'd0, done}, {31'd0, x[8]});
        check({tag, " cnt"},  {24'd0, cnt_out}, {24'd0, x[7:0]});
    endtask

    task automatic step(input string tag, input logic e, input logic ld, input logic [7:0] pin,
                        input logic [1:0] m, input logic st, input logic sp,
                        input logic xpe, input logic xbusy, input logic xdone, input logic [7:0] xcnt);
        exp_q.push_back({xpe, xbusy, xdone, xcnt});
        drive(1'b1, e, ld, pin, m, 8'd0, st, sp);
        score(tag);
    endtask

    initial begin
        int cycles;

        rst = 1'b0; en = 1'b0; load = 1'b0; period_in = '0; mode = 2'b00;
        burst_len = '0; start = 1'b0; stop = 1'b0;

        // Reset, then continuous with the default period 5
        add(0,1,0,0,0,0,0,0, 0,0,0,0);
        add(1,1,0,0,0,0,0,0, 0,1,0,0);
        for (int k = 1; k <= 3; k++) begin
            for (int j = 0; j < 4; j++) add(1,1,0,0,0,0,0,0, 0,1,0,8'(k-1));
            add(1,1,0,0,0,0,0,0, 1,1,0,8'(k));
        end
        // en dropped for 3 cycles at phase 2: pulse slips by exactly 3
        add(1,1,0,0,0,0,0,0, 0,1,0,3);
        add(1,1,0,0,0,0,0,0, 0,1,0,3);
        for (int j = 0; j < 3; j++) add(1,0,0,0,0,0,0,0, 0,1,0,3);
        add(1,1,0,0,0,0,0,0, 0,1,0,3);
        add(1,1,0,0,0,0,0,0, 0,1,0,3);
        add(1,1,0,0,0,0,0,0, 1,1,0,4);
        add(1,1,0,0,0,0,0,0, 0,1,0,4);
        // load period 2 at phase 3, then period 0
        add(1,1,0,0,0,0,0,0, 0,1,0,4);
        add(1,1,0,0,0,0,0,0, 0,1,0,4);
        add(1,1,1,2,0,0,0,0, 0,1,0,4);
        add(1,1,0,0,0,0,0,0, 0,1,0,4);
        add(1,1,0,0,0,0,0,0, 1,1,0,5);
        add(1,1,0,0,0,0,0,0, 0,1,0,5);
        add(1,1,0,0,0,0,0,0, 1,1,0,6);
        add(1,1,1,0,0,0,0,0, 0,1,0,6);
        add(1,1,0,0,0,0,0,0, 1,1,0,7);
        add(1,1,0,0,0,0,0,0, 1,1,0,8);
        add(1,1,0,0,0,0,0,0, 1,1,0,9);
        // stop, program period 4, burst of 3 with a stray start mid-run
        add(1,1,0,0,2,0,0,1, 0,0,0,9);
        add(1,1,1,4,2,0,0,0, 0,0,0,9);
        add(1,1,0,0,2,3,1,0, 0,1,0,0);
        add(1,1,0,0,2,0,0,0, 0,1,0,0);
        add(1,1,0,0,2,0,1,0, 0,1,0,0);
        add(1,1,0,0,2,0,0,0, 0,1,0,0);
        add(1,1,0,0,2,0,0,0, 1,1,0,1);
        for (int j = 0; j < 3; j++) add(1,1,0,0,2,0,0,0, 0,1,0,1);
        add(1,1,0,0,2,0,0,0, 1,1,0,2);
        for (int j = 0; j < 3; j++) add(1,1,0,0,2,0,0,0, 0,1,0,2);
        add(1,1,0,0,2,0,0,0, 1,0,1,3);
        add(1,1,0,0,2,0,0,0, 0,0,0,3);
        // one-shot, stop mid-count, restart from phase 0
        add(1,1,0,0,1,0,1,0, 0,1,0,0);
        add(1,1,0,0,1,0,0,0, 0,1,0,0);
        add(1,1,0,0,1,0,0,0, 0,1,0,0);
        add(1,1,0,0,1,0,0,1, 0,0,0,0);
        add(1,1,0,0,1,0,0,0, 0,0,0,0);
        add(1,1,0,0,1,0,1,0, 0,1,0,0);
        for (int j = 0; j < 3; j++) add(1,1,0,0,1,0,0,0, 0,1,0,0);
        add(1,1,0,0,1,0,0,0, 1,0,1,1);
        add(1,1,0,0,1,0,0,0, 0,0,0,1);
        // reset mid-burst on the edge a pulse is due, then burst_len 0
        add(1,1,0,0,2,2,1,0, 0,1,0,0);
        for (int j = 0; j < 3; j++) add(1,1,0,0,2,0,0,0, 0,1,0,0);
        add(0,1,0,0,2,0,0,0, 0,0,0,0);
        add(1,1,0,0,2,0,0,0, 0,0,0,0);
        add(1,1,0,0,2,0,1,0, 0,1,0,0);
        for (int j = 0; j < 4; j++) add(1,1,0,0,2,0,0,0, 0,1,0,0);
        add(1,1,0,0,2,0,0,0, 1,0,1,1);
        add(1,1,0,0,2,0,0,0, 0,0,0,1);

        #2;
        for (int i = 0; i < vecs.size(); i++) begin
            exp_q.push_back({vecs[i].exp_p_e, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_cnt});
            drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].period_in, vecs[i].mode,
                  vecs[i].burst_len, vecs[i].start, vecs[i].stop);
            score($sformatf("v%0d", i));
        end

        // Mode 11 runs continuously; period 1 gives back-to-back pulses;
        // stop in continuous re-enters RUN one edge later with cnt cleared.
        step("m11 enter", 1, 1, 8'd1, 2'b11, 0, 0, 0, 1, 0, 8'd0);
        step("p1 a",      1, 0, 8'd0, 2'b11, 0, 0, 1, 1, 0, 8'd1);
        step("p1 b",      1, 0, 8'd0, 2'b11, 0, 0, 1, 1, 0, 8'd2);
        step("cont stop", 1, 0, 8'd0, 2'b11, 0, 1, 0, 0, 0, 8'd2);
        step("cont reent",1, 0, 8'd0, 2'b11, 0, 0, 0, 1, 0, 8'd0);
        step("p1 c",      1, 0, 8'd0, 2'b11, 0, 0, 1, 1, 0, 8'd1);
        step("load 3",    1, 1, 8'd3, 2'b11, 0, 0, 0, 1, 0, 8'd1);

        // bounded wait for the next pulse after the period-3 reload
        cycles = 0;
        load = 1'b0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!p_e && cycles < 10);
        check("p3 latency", cycles, 3);
        check("p3 cnt", {24'd0, cnt_out}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
